// File: rtl/fp_pe_seq_ctrl_if.sv
// fp_pe_seq_ctrl_if: scheduler-side handshake and bus signals of the fp_pe tile sequencer.
//   start / cfg_num_tiles / cfg_num_passes : job request, config sampled on start
//   busy / cfg_err / done                  : job status back to the scheduler
//   w_valid / w_ready                      : weight-load beats
//   d_valid / d_ready                      : activation beats
//   res_valid / res_pass_idx               : per-pass result strobe and its pass index
// master = scheduler/feeder side, slave = sequencer side.
interface fp_pe_seq_ctrl_if #(
    parameter int PW = 8
);
    logic          start;
    logic [6:0]    cfg_num_tiles;
    logic [PW-1:0] cfg_num_passes;
    logic          busy;
    logic          cfg_err;
    logic          w_valid;
    logic          w_ready;
    logic          d_valid;
    logic          d_ready;
    logic          res_valid;
    logic [PW-1:0] res_pass_idx;
    logic          done;

    modport master (
        output start, cfg_num_tiles, cfg_num_passes, w_valid, d_valid,
        input  busy, cfg_err, w_ready, d_ready, res_valid, res_pass_idx, done
    );

    modport slave (
        input  start, cfg_num_tiles, cfg_num_passes, w_valid, d_valid,
        output busy, cfg_err, w_ready, d_ready, res_valid, res_pass_idx, done
    );
endinterface

// File: rtl/fp_pe_seq_ctrl.sv
// fp_pe_seq_ctrl: sequencer for one fp_pe tile (weight load, pointer align, compute passes, result strobe).
// Ports:
//   clk, reset (synchronous, active-low)
//   bus                : fp_pe_seq_ctrl_if.slave (start/cfg/busy/cfg_err/done, w and d handshakes, results)
//   o_pe_is_new_weight : toggle level, one toggle per accepted weight beat
//   o_pe_read_enable   : buffer read strobe (ALIGN cycles and accepted activation beats)
//   o_pe_data_load     : accepted activation beat delayed one cycle
//   o_pe_reset_pp      : partial-product clear
//   o_perf_active_cyc, o_perf_stall_cyc : only when FP_PE_SEQ_PERF_EN is defined
// Optional feature macro: FP_PE_SEQ_PERF_EN (busy-cycle and compute-stall counters).
module fp_pe_seq_ctrl #(
    parameter int DEPTH    = 64,
    parameter int PIPE_LAT = 3,
    parameter int PW       = 8
) (
    input  logic              clk,
    input  logic              reset,
    fp_pe_seq_ctrl_if.slave   bus,
    output logic              o_pe_is_new_weight,
    output logic              o_pe_read_enable,
    output logic              o_pe_data_load,
    output logic              o_pe_reset_pp
`ifdef FP_PE_SEQ_PERF_EN
    ,
    output logic [31:0]       o_perf_active_cyc,
    output logic [31:0]       o_perf_stall_cyc
`endif
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_ALIGN   = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int          DW      = $clog2(PIPE_LAT + 1);
    localparam logic [6:0]  DEPTH_C = 7'(DEPTH);
    localparam logic [DW-1:0] PIPE_C = DW'(PIPE_LAT);

    logic [2:0]    r_state;
    logic [6:0]    r_n;
    logic [PW-1:0] r_p;
    logic [PW-1:0] r_pass;
    // r_cnt doubles as beat counter in LOAD/COMPUTE and as buffer pointer in ALIGN
    logic [6:0]    r_cnt;
    logic [DW-1:0] r_dcnt;
    logic          r_toggle;
    logic          r_data_load;
    logic          r_cfg_err;

    logic w_cfg_ok;
    logic w_start_ok;
    logic w_res;
    logic w_more;
    logic w_ptr_zero;

    assign w_cfg_ok   = bus.cfg_num_tiles != 7'd0 && bus.cfg_num_tiles <= DEPTH_C && bus.cfg_num_passes != '0;
    assign w_start_ok = r_state == S_IDLE && bus.start && w_cfg_ok;
    // result is strobed on the cycle the drain count reaches zero, PIPE_LAT cycles after the last read
    assign w_res      = r_state == S_DRAIN && r_dcnt == DW'(1);
    assign w_more     = (r_pass + PW'(1)) < r_p;
    // N == DEPTH leaves the shared pointer back at 0, so no alignment is needed
    assign w_ptr_zero = r_n == DEPTH_C;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_p         <= '0;
            r_pass      <= '0;
            r_cnt       <= '0;
            r_dcnt      <= '0;
            r_toggle    <= 1'b0;
            r_data_load <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err   <= r_state == S_IDLE && bus.start && !w_cfg_ok;
            r_data_load <= r_state == S_COMPUTE && bus.d_valid;
            case (r_state)
                S_IDLE: if (w_start_ok) begin
                    r_n     <= bus.cfg_num_tiles;
                    r_p     <= bus.cfg_num_passes;
                    r_pass  <= '0;
                    r_cnt   <= '0;
                    r_state <= S_LOAD;
                end
                S_LOAD: if (bus.w_valid) begin
                    r_toggle <= ~r_toggle;
                    r_cnt    <= r_cnt + 7'd1;
                    if (r_cnt == r_n - 7'd1) begin
                        r_state <= w_ptr_zero ? S_COMPUTE : S_ALIGN;
                        r_cnt   <= w_ptr_zero ? 7'd0 : r_n;
                    end
                end
                S_ALIGN: begin
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt == DEPTH_C - 7'd1) begin
                        r_cnt   <= 7'd0;
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: if (bus.d_valid) begin
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt == r_n - 7'd1) begin
                        r_dcnt  <= PIPE_C;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_dcnt <= r_dcnt - DW'(1);
                    if (w_res) begin
                        r_pass  <= r_pass + PW'(1);
                        r_cnt   <= w_ptr_zero ? 7'd0 : r_n;
                        r_state <= !w_more ? S_DONE : w_ptr_zero ? S_COMPUTE : S_ALIGN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy          = r_state != S_IDLE;
    assign bus.cfg_err       = r_cfg_err;
    assign bus.w_ready       = r_state == S_LOAD;
    assign bus.d_ready       = r_state == S_COMPUTE;
    assign bus.res_valid     = w_res;
    assign bus.res_pass_idx  = r_pass;
    assign bus.done          = r_state == S_DONE;
    assign o_pe_is_new_weight = r_toggle;
    assign o_pe_read_enable   = r_state == S_ALIGN || (r_state == S_COMPUTE && bus.d_valid);
    assign o_pe_data_load     = r_data_load;
    // partial products accumulate only while computing and draining toward the strobe
    assign o_pe_reset_pp      = !(r_state == S_COMPUTE || (r_state == S_DRAIN && !w_res));

`ifdef FP_PE_SEQ_PERF_EN
    logic [31:0] r_perf_act;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_act   <= '0;
            r_perf_stall <= '0;
        end else begin
            r_perf_act   <= w_start_ok ? '0 :
                            (r_state != S_IDLE && r_perf_act != '1) ? r_perf_act + 32'd1 : r_perf_act;
            r_perf_stall <= w_start_ok ? '0 :
                            (r_state == S_COMPUTE && !bus.d_valid && r_perf_stall != '1) ? r_perf_stall + 32'd1 : r_perf_stall;
        end
    end

    assign o_perf_active_cyc = r_perf_act;
    assign o_perf_stall_cyc  = r_perf_stall;
`endif
endmodule

// File: tb/tb_fp_pe_seq_ctrl.sv
// tb_fp_pe_seq_ctrl: directed table-driven bench for fp_pe_seq_ctrl, plus reset and mid-job reset sequences.
module tb_fp_pe_seq_ctrl;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pe_nw, pe_re, pe_dl, pe_rp;
`ifdef FP_PE_SEQ_PERF_EN
    logic [31:0] perf_act, perf_stall;
`endif

    fp_pe_seq_ctrl_if #(.PW(PW)) bus ();

    fp_pe_seq_ctrl #(.DEPTH(64), .PIPE_LAT(3), .PW(PW)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .o_pe_is_new_weight (pe_nw),
        .o_pe_read_enable   (pe_re),
        .o_pe_data_load     (pe_dl),
        .o_pe_reset_pp      (pe_rp)
`ifdef FP_PE_SEQ_PERF_EN
        ,
        .o_perf_active_cyc  (perf_act),
        .o_perf_stall_cyc   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s/%s: got %0d want %0d", tag, name, act, exp);
        end
    endtask

    typedef struct {
        int n; int p; bit gap; int restart; int err; int tog; int align; int run;
        int reads; int res; int dn; int stall; int act;
    } vec_t;

    vec_t tv[8];

    task automatic run_job(input vec_t v, input string tag);
        int errs = 0, tog = 0, align = 0, run = 0, run_bad = 0, reads = 0, res = 0, dn = 0;
        int last_rd = -100, last_res = -100, lat_bad = 0, idx_bad = 0, dl_bad = 0, rp_bad = 0, re_bad = 0;
        int busy_cyc = 0, lim;
        logic prev_nw, prev_rd, ph;
        prev_nw = pe_nw;
        prev_rd = 1'b0;
        ph = 1'b0;
        lim = v.err != 0 ? 8 : 3000;
        for (int cyc = 0; cyc < lim; cyc++) begin
            @(negedge clk);
            bus.start          = cyc == 0 || (v.restart != 0 && cyc == v.restart);
            bus.cfg_num_tiles  = cyc == 0 ? 7'(v.n) : 7'd0;
            bus.cfg_num_passes = PW'(v.p);
            bus.w_valid        = 1'b1;
            bus.d_valid        = v.gap ? ~ph : 1'b1;
            #1;
            if (bus.cfg_err) errs++;
            if (bus.busy) busy_cyc++;
            if (pe_nw != prev_nw) tog++;
            prev_nw = pe_nw;
            if (pe_re && !bus.d_ready) begin
                align++;
                run++;
            end else if (run != 0) begin
                if (run != v.run) run_bad++;
                run = 0;
            end
            if (bus.d_ready && pe_re != bus.d_valid) re_bad++;
            if (pe_dl != prev_rd) dl_bad++;
            prev_rd = pe_re && bus.d_ready;
            if (prev_rd) begin
                reads++;
                last_rd = cyc;
            end
            if (bus.d_ready) ph = ~ph;
            if (bus.res_valid) begin
                if (cyc - last_rd != 3) lat_bad++;
                if (int'(bus.res_pass_idx) != res) idx_bad++;
                if (!pe_rp) rp_bad++;
                res++;
                last_res = cyc;
            end
            if (bus.done) begin
                dn++;
                if (cyc - last_res != 1) lat_bad++;
            end
            if (dn != 0 && !bus.done && !bus.busy) break;
        end
        bus.start = 1'b0;
        bus.w_valid = 1'b0;
        bus.d_valid = 1'b0;
        chk(tag, "cfg_err", errs, v.err);
        chk(tag, "busy_cyc", busy_cyc, v.act);
        chk(tag, "toggles", tog, v.tog);
        chk(tag, "align_cyc", align, v.align);
        chk(tag, "align_run_bad", run_bad, 0);
        chk(tag, "reads", reads, v.reads);
        chk(tag, "read_en_bad", re_bad, 0);
        chk(tag, "data_load_bad", dl_bad, 0);
        chk(tag, "res_count", res, v.res);
        chk(tag, "res_idx_bad", idx_bad, 0);
        chk(tag, "reset_pp_bad", rp_bad, 0);
        chk(tag, "latency_bad", lat_bad, 0);
        chk(tag, "done_count", dn, v.dn);
`ifdef FP_PE_SEQ_PERF_EN
        if (v.err == 0) begin
            chk(tag, "perf_stall", int'(perf_stall), v.stall);
            chk(tag, "perf_active", int'(perf_act), v.act);
        end
`endif
    endtask

    initial begin
        tv[0] = '{4, 1, 1'b0, 10, 0, 4, 60, 60, 4, 1, 1, 0, 72};
        tv[1] = '{64, 2, 1'b0, 0, 0, 64, 0, 0, 128, 2, 1, 0, 199};
        tv[2] = '{8, 1, 1'b1, 0, 0, 8, 56, 56, 8, 1, 1, 7, 83};
        tv[3] = '{5, 3, 1'b0, 0, 0, 5, 177, 59, 15, 3, 1, 0, 207};
        tv[4] = '{0, 1, 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[5] = '{65, 1, 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[6] = '{4, 0, 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[7] = '{1, 1, 1'b0, 0, 0, 1, 63, 63, 1, 1, 1, 0, 69};

        bus.start = 1'b0;
        bus.cfg_num_tiles = 7'd0;
        bus.cfg_num_passes = '0;
        bus.w_valid = 1'b0;
        bus.d_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset", "busy", int'(bus.busy), 0);
        chk("reset", "reset_pp", int'(pe_rp), 1);
        chk("reset", "w_ready", int'(bus.w_ready), 0);
        chk("reset", "d_ready", int'(bus.d_ready), 0);
        chk("reset", "done", int'(bus.done), 0);
        chk("reset", "res_valid", int'(bus.res_valid), 0);
        chk("reset", "res_pass_idx", int'(bus.res_pass_idx), 0);
        chk("reset", "cfg_err", int'(bus.cfg_err), 0);
        chk("reset", "new_weight", int'(pe_nw), 0);
        chk("reset", "read_en", int'(pe_re), 0);
        chk("reset", "data_load", int'(pe_dl), 0);
`ifdef FP_PE_SEQ_PERF_EN
        chk("reset", "perf_active", int'(perf_act), 0);
        chk("reset", "perf_stall", int'(perf_stall), 0);
`endif

        for (int i = 0; i < 8; i++) run_job(tv[i], $sformatf("vec%0d", i));

        begin
            int reads = 0, strays = 0;
            for (int cyc = 0; cyc < 200 && reads < 5; cyc++) begin
                @(negedge clk);
                bus.start          = cyc == 0;
                bus.cfg_num_tiles  = 7'd10;
                bus.cfg_num_passes = PW'(1);
                bus.w_valid        = 1'b1;
                bus.d_valid        = 1'b1;
                #1;
                if (pe_re && bus.d_ready) reads++;
            end
            chk("midrst", "reached_beat5", reads, 5);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            #1;
            chk("midrst", "busy", int'(bus.busy), 0);
            chk("midrst", "reset_pp", int'(pe_rp), 1);
            chk("midrst", "done", int'(bus.done), 0);
            chk("midrst", "res_valid", int'(bus.res_valid), 0);
            chk("midrst", "read_en", int'(pe_re), 0);
            reset = 1'b1;
            for (int cyc = 0; cyc < 12; cyc++) begin
                @(negedge clk);
                #1;
                if (bus.done || bus.res_valid || bus.busy) strays++;
            end
            chk("midrst", "strays", strays, 0);
            bus.w_valid = 1'b0;
            bus.d_valid = 1'b0;
        end

        run_job(tv[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
